// File: rtl/pe_mem_pkg.sv
// Shared encodings for the PE local-memory sequencer.
// Command opcodes, FSM states and the memory read-return latency.
package pe_mem_pkg;

   typedef enum logic [1:0] {
      OP_LOAD  = 2'b00,
      OP_DRAIN = 2'b01,
      OP_CLEAR = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LOAD  = 3'd1,
      ST_DRAIN = 3'd2,
      ST_CLEAR = 3'd3,
      ST_DONE  = 3'd4
   } state_e;

   // Edges from registering a read address to the data being pushable.
   localparam int unsigned DRAIN_LAT = 2;

endpackage

// File: rtl/pe_mem_rd_fifo.sv
// Read-return FIFO for DRAIN; shift-style so the head sits directly in a register.
// Exposes its occupancy so the issuer can run credit-based flow control.
module pe_mem_rd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned WIDTH = 8
) (
   input  logic                         w_clk,
   input  logic                         w_rst_n,
   input  logic                         w_push,
   input  logic [WIDTH-1:0]             w_push_data,
   input  logic                         w_pop,
   output logic                         r_head_valid,
   output logic [WIDTH-1:0]             r_head_data,
   output logic [$clog2(DEPTH+1)-1:0]   r_count
);

   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [WIDTH-1:0] store_q [DEPTH];
   logic [WIDTH-1:0] store_d [DEPTH];
   logic [CNT_W-1:0] count_d;
   logic             pop_ok;
   logic             push_ok;

   assign pop_ok  = w_pop && r_head_valid;
   assign push_ok = w_push && ((r_count != CNT_W'(DEPTH)) || pop_ok);

   // Pop shifts every entry toward the head; push lands just behind the last valid one.
   always_comb begin
      store_d = store_q;
      count_d = r_count;
      if (pop_ok) begin
         for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
            store_d[i] = store_q[i+1];
         end
         count_d = count_d - CNT_W'(1);
      end
      if (push_ok) begin
         store_d[IDX_W'(count_d)] = w_push_data;
         count_d = count_d + CNT_W'(1);
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            store_q[i] <= '0;
         end
         r_count      <= '0;
         r_head_valid <= 1'b0;
      end else begin
         store_q      <= store_d;
         r_count      <= count_d;
         r_head_valid <= (count_d != '0);
      end
   end

   assign r_head_data = store_q[0];

endmodule

// File: rtl/pe_mem_ctrl.sv
// Sole initiator of one PE's local memory: LOAD stream-in, DRAIN stream-out, CLEAR.
// Drives the memory port registers directly; every output is a flop.
module pe_mem_ctrl
   import pe_mem_pkg::*;
#(
   parameter int unsigned NUM_ROWS    = 64,
   parameter int unsigned ADDR_WIDTH  = $clog2(NUM_ROWS),
   parameter int unsigned NUM_BITS    = 8,
   parameter int unsigned DRAIN_DEPTH = 4
) (
   input  logic                  w_clk,
   input  logic                  w_rst_n,
   input  logic                  w_cmd_valid,
   output logic                  r_cmd_ready,
   input  logic [1:0]            w_cmd_op,
   input  logic [ADDR_WIDTH-1:0] w_cmd_base,
   input  logic [ADDR_WIDTH:0]   w_cmd_len,
   input  logic                  w_in_valid,
   output logic                  r_in_ready,
   input  logic [NUM_BITS-1:0]   w_in_data,
   output logic                  r_out_valid,
   input  logic                  w_out_ready,
   output logic [NUM_BITS-1:0]   r_out_data,
   output logic                  r_mem_ready,
   output logic                  r_mem_rw,
   output logic [ADDR_WIDTH-1:0] r_mem_addr,
   output logic [NUM_BITS-1:0]   r_mem_wdata,
   input  logic [NUM_BITS-1:0]   w_mem_rdata,
   output logic                  r_busy,
   output logic                  r_done
);

   localparam int unsigned CNT_W  = ADDR_WIDTH + 1;
   localparam int unsigned FCNT_W = $clog2(DRAIN_DEPTH + 1);

   state_e                state_q, state_d;
   logic [CNT_W-1:0]      beats_q, beats_d;
   logic [CNT_W-1:0]      outs_q, outs_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [DRAIN_LAT-1:0]  infl_q, infl_d;

   op_e                   cmd_op;
   logic [CNT_W-1:0]      len_sat;
   logic [ADDR_WIDTH-1:0] base_mod;
   logic                  cmd_hs, in_hs, out_hs, issue, credit_ok;
   logic                  fifo_push;
   logic [FCNT_W-1:0]     fifo_count;
   int unsigned           occupancy;

   logic                  cmd_ready_d, in_ready_d, mem_ready_d, mem_rw_d;
   logic                  busy_d, done_d;
   logic [ADDR_WIDTH-1:0] mem_addr_d;
   logic [NUM_BITS-1:0]   mem_wdata_d;

   function automatic logic [ADDR_WIDTH-1:0] addr_inc(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) == NUM_ROWS - 1) ? '0 : a + ADDR_WIDTH'(1);
   endfunction

   assign cmd_op   = op_e'(w_cmd_op);
   assign len_sat  = (32'(w_cmd_len) > NUM_ROWS) ? CNT_W'(NUM_ROWS) : w_cmd_len;
   assign base_mod = (32'(w_cmd_base) >= NUM_ROWS) ?
                     ADDR_WIDTH'(32'(w_cmd_base) - NUM_ROWS) : w_cmd_base;

   assign cmd_hs = w_cmd_valid && r_cmd_ready;
   assign in_hs  = w_in_valid && r_in_ready;
   assign out_hs = r_out_valid && w_out_ready;

   // Credit: FIFO entries plus reads still travelling through the memory.
   always_comb begin
      occupancy = 32'(fifo_count);
      for (int unsigned i = 0; i < DRAIN_LAT; i++) begin
         occupancy = occupancy + 32'(infl_q[i]);
      end
   end

   assign credit_ok = (occupancy < DRAIN_DEPTH);
   assign issue     = (state_q == ST_DRAIN) && (beats_q != '0) && credit_ok;
   assign infl_d    = {infl_q[DRAIN_LAT-2:0], issue};
   assign fifo_push = infl_q[DRAIN_LAT-1];

   // Next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_hs) begin
               if (len_sat == '0) begin
                  state_d = ST_DONE;
               end else begin
                  case (cmd_op)
                     OP_LOAD:  state_d = ST_LOAD;
                     OP_DRAIN: state_d = ST_DRAIN;
                     OP_CLEAR: state_d = ST_CLEAR;
                     default:  state_d = ST_DONE;
                  endcase
               end
            end
         end
         ST_LOAD:  if (beats_q == '0) state_d = ST_DONE;
         ST_DRAIN: if (out_hs && (outs_q == CNT_W'(1))) state_d = ST_DONE;
         ST_CLEAR: if (beats_q == '0) state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Beat counter, output counter and address generator; CLEAR reuses beats as its phase bit.
   always_comb begin
      beats_d = beats_q;
      outs_d  = outs_q;
      addr_d  = addr_q;
      case (state_q)
         ST_IDLE: begin
            if (cmd_hs) begin
               beats_d = (cmd_op == OP_CLEAR) ? CNT_W'(1) : len_sat;
               outs_d  = len_sat;
               addr_d  = base_mod;
            end
         end
         ST_LOAD: begin
            if (in_hs) begin
               beats_d = beats_q - CNT_W'(1);
               addr_d  = addr_inc(addr_q);
            end
         end
         ST_DRAIN: begin
            if (issue) begin
               beats_d = beats_q - CNT_W'(1);
               addr_d  = addr_inc(addr_q);
            end
            if (out_hs) outs_d = outs_q - CNT_W'(1);
         end
         ST_CLEAR: beats_d = '0;
         default: ;
      endcase
   end

   // Output next values; the memory is written only the cycle after an accepted LOAD beat.
   always_comb begin
      cmd_ready_d = (state_d == ST_IDLE);
      busy_d      = (state_d != ST_IDLE);
      done_d      = (state_d == ST_DONE);
      in_ready_d  = (state_d == ST_LOAD) && (beats_d != '0);
      mem_ready_d = !((state_q == ST_CLEAR) && (beats_q != '0));
      mem_rw_d    = in_hs;
      mem_addr_d  = r_mem_addr;
      mem_wdata_d = r_mem_wdata;
      if (in_hs || issue) mem_addr_d = addr_q;
      if (in_hs) mem_wdata_d = w_in_data;
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         state_q     <= ST_IDLE;
         r_cmd_ready <= 1'b0;
         r_in_ready  <= 1'b0;
         r_mem_ready <= 1'b0;
         r_mem_rw    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         state_q     <= state_d;
         r_cmd_ready <= cmd_ready_d;
         r_in_ready  <= in_ready_d;
         r_mem_ready <= mem_ready_d;
         r_mem_rw    <= mem_rw_d;
         r_mem_addr  <= mem_addr_d;
         r_mem_wdata <= mem_wdata_d;
         r_busy      <= busy_d;
         r_done      <= done_d;
      end
   end

   always_ff @(posedge w_clk or negedge w_rst_n) begin
      if (!w_rst_n) begin
         beats_q <= '0;
         outs_q  <= '0;
         addr_q  <= '0;
         infl_q  <= '0;
      end else begin
         beats_q <= beats_d;
         outs_q  <= outs_d;
         addr_q  <= addr_d;
         infl_q  <= infl_d;
      end
   end

   pe_mem_rd_fifo #(
      .DEPTH (DRAIN_DEPTH),
      .WIDTH (NUM_BITS)
   ) u_fifo (
      .w_clk        (w_clk),
      .w_rst_n      (w_rst_n),
      .w_push       (fifo_push),
      .w_push_data  (w_mem_rdata),
      .w_pop        (out_hs),
      .r_head_valid (r_out_valid),
      .r_head_data  (r_out_data),
      .r_count      (fifo_count)
   );

endmodule

// File: tb/tb_pe_mem_ctrl.sv
// Directed bench for pe_mem_ctrl with a behavioural model of the attached PE memory.
module tb_pe_mem_ctrl;
   import pe_mem_pkg::*;

   logic       w_clk;
   logic       w_rst_n;
   logic       w_cmd_valid;
   logic       r_cmd_ready;
   logic [1:0] w_cmd_op;
   logic [5:0] w_cmd_base;
   logic [6:0] w_cmd_len;
   logic       w_in_valid;
   logic       r_in_ready;
   logic [7:0] w_in_data;
   logic       r_out_valid;
   logic       w_out_ready;
   logic [7:0] r_out_data;
   logic       r_mem_ready;
   logic       r_mem_rw;
   logic [5:0] r_mem_addr;
   logic [7:0] r_mem_wdata;
   logic [7:0] w_mem_rdata;
   logic       r_busy;
   logic       r_done;

   int n_assert = 0;
   int n_fail   = 0;

   logic [7:0] mem [64];
   logic [7:0] ref_mem [64];

   int   cyc = 0;
   int   wr_cnt = 0;
   int   act_cnt = 0;
   int   done_cnt = 0;
   int   max_occ = 0;
   logic [7:0] out_q [$];
   int         out_cyc [$];

   pe_mem_ctrl dut (
      .w_clk       (w_clk),
      .w_rst_n     (w_rst_n),
      .w_cmd_valid (w_cmd_valid),
      .r_cmd_ready (r_cmd_ready),
      .w_cmd_op    (w_cmd_op),
      .w_cmd_base  (w_cmd_base),
      .w_cmd_len   (w_cmd_len),
      .w_in_valid  (w_in_valid),
      .r_in_ready  (r_in_ready),
      .w_in_data   (w_in_data),
      .r_out_valid (r_out_valid),
      .w_out_ready (w_out_ready),
      .r_out_data  (r_out_data),
      .r_mem_ready (r_mem_ready),
      .r_mem_rw    (r_mem_rw),
      .r_mem_addr  (r_mem_addr),
      .r_mem_wdata (r_mem_wdata),
      .w_mem_rdata (w_mem_rdata),
      .r_busy      (r_busy),
      .r_done      (r_done)
   );

   initial w_clk = 1'b0;
   always #5 w_clk = ~w_clk;

   // PE memory: ready low clears all rows; rw=1 writes; rw=0 captures a row.
   always @(posedge w_clk) begin
      if (!r_mem_ready) begin
         for (int i = 0; i < 64; i++) mem[i] <= 8'h00;
      end else if (r_mem_rw) begin
         mem[r_mem_addr] <= r_mem_wdata;
      end else begin
         w_mem_rdata <= mem[r_mem_addr];
      end
   end

   always @(posedge w_clk) begin
      cyc <= cyc + 1;
      if (w_rst_n) begin
         if (r_out_valid && w_out_ready) begin
            out_q.push_back(r_out_data);
            out_cyc.push_back(cyc);
         end
         if (r_mem_rw) wr_cnt <= wr_cnt + 1;
         if (r_mem_rw || !r_mem_ready) act_cnt <= act_cnt + 1;
         if (r_done) done_cnt <= done_cnt + 1;
         if (32'(dut.u_fifo.r_count) > max_occ) max_occ <= 32'(dut.u_fifo.r_count);
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge.
   task automatic send_cmd(input logic [1:0] op, input int base, input int len);
      int k = 0;
      w_cmd_valid = 1'b1;
      w_cmd_op    = op;
      w_cmd_base  = 6'(base);
      w_cmd_len   = 7'(len);
      while (!r_cmd_ready && k < 50) begin
         @(negedge w_clk);
         k++;
      end
      check("cmd_ready_wait", 32'(k < 50), 1);
      @(negedge w_clk);
      w_cmd_valid = 1'b0;
   endtask

   task automatic load4(input int base, input logic [31:0] words, input int beats,
                        input bit wait_done);
      int k;
      int d0 = done_cnt;
      int w0 = wr_cnt;
      send_cmd(OP_LOAD, base, 4);
      for (int i = 0; i < beats; i++) begin
         for (int g = 0; g < (i % 3); g++) @(negedge w_clk);
         w_in_valid = 1'b1;
         w_in_data  = words[31-8*i -: 8];
         k = 0;
         while (!r_in_ready && k < 50) begin
            @(negedge w_clk);
            k++;
         end
         check("in_ready_wait", 32'(k < 50), 1);
         @(negedge w_clk);
         w_in_valid = 1'b0;
      end
      if (wait_done) begin
         k = 0;
         while (done_cnt == d0 && k < 50) begin
            @(negedge w_clk);
            k++;
         end
         check("load_done_wait", 32'(k < 50), 1);
         repeat (3) @(negedge w_clk);
         check("load_write_cycles", 32'(wr_cnt - w0), 32'(beats));
         check("load_done_pulses", 32'(done_cnt - d0), 1);
      end
   endtask

   task automatic drain(input int base, input int len, input int len_eff,
                        input bit bp, input bit chk_lat);
      int k  = 0;
      int d0 = done_cnt;
      int qb = out_q.size();
      w_out_ready = 1'b1;
      send_cmd(OP_DRAIN, base, len);
      if (chk_lat) begin
         @(negedge w_clk);
         @(negedge w_clk);
         check("drain_valid_early", 32'(r_out_valid), 0);
         @(negedge w_clk);
         check("drain_valid_at_3", 32'(r_out_valid), 1);
      end
      while (done_cnt == d0 && k < 2000) begin
         if (bp) w_out_ready = ((k % 4) == 0) || ((k % 4) == 3);
         @(negedge w_clk);
         k++;
      end
      w_out_ready = 1'b1;
      check("drain_done_wait", 32'(k < 2000), 1);
      check("drain_word_count", 32'(out_q.size() - qb), 32'(len_eff));
      for (int i = 0; i < len_eff && (qb + i) < out_q.size(); i++) begin
         check("drain_data", 32'(out_q[qb+i]), 32'(ref_mem[(base+i)%64]));
      end
      if (chk_lat && out_q.size() >= qb + 4) begin
         check("drain_consecutive", 32'(out_cyc[qb+3] - out_cyc[qb]), 3);
      end
   endtask

   initial begin
      int a0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      w_cmd_valid = 1'b0;
      w_cmd_op    = 2'b00;
      w_cmd_base  = '0;
      w_cmd_len   = '0;
      w_in_valid  = 1'b0;
      w_in_data   = '0;
      w_out_ready = 1'b1;
      w_rst_n     = 1'b1;
      #1 w_rst_n  = 1'b0;

      // Reset held over two edges
      @(negedge w_clk);
      @(negedge w_clk);
      check("reset_ctrl_outs",
            32'({r_cmd_ready, r_in_ready, r_out_valid, r_mem_ready, r_mem_rw, r_busy, r_done}), 0);
      check("reset_mem_bus", 32'({r_mem_addr, r_mem_wdata, r_out_data}), 0);
      w_rst_n = 1'b1;
      @(negedge w_clk);
      check("post_reset_cmd_ready", 32'(r_cmd_ready), 1);
      check("post_reset_mem_ready", 32'(r_mem_ready), 1);
      drain(0, 4, 4, 1'b0, 1'b0);

      // LOAD rows 5..8 with in_valid gaps, then drain them back
      load4(5, 32'h11223344, 4, 1'b1);
      ref_mem[5] = 8'h11; ref_mem[6] = 8'h22; ref_mem[7] = 8'h33; ref_mem[8] = 8'h44;
      for (int i = 5; i < 9; i++) check("row_after_load", 32'(mem[i]), 32'(ref_mem[i]));
      drain(5, 4, 4, 1'b0, 1'b1);

      // Address wrap
      load4(62, 32'hA0A1A2A3, 4, 1'b1);
      ref_mem[62] = 8'hA0; ref_mem[63] = 8'hA1; ref_mem[0] = 8'hA2; ref_mem[1] = 8'hA3;
      check("wrap_row62", 32'(mem[62]), 32'h A0);
      check("wrap_row63", 32'(mem[63]), 32'h A1);
      check("wrap_row0",  32'(mem[0]),  32'h A2);
      check("wrap_row1",  32'(mem[1]),  32'h A3);
      drain(62, 4, 4, 1'b0, 1'b0);

      // Backpressure: rows 62,63,0..5 -> A0 A1 A2 A3 00 00 00 11
      drain(62, 8, 8, 1'b1, 1'b0);
      check("fifo_max_occ", 32'(max_occ <= 4), 1);

      // CLEAR: ready low exactly one cycle, done two cycles after accept
      send_cmd(OP_CLEAR, 0, 1);
      check("clear_ready_c0", 32'(r_mem_ready), 1);
      @(negedge w_clk);
      check("clear_ready_c1", 32'(r_mem_ready), 0);
      @(negedge w_clk);
      check("clear_ready_c2", 32'(r_mem_ready), 1);
      check("clear_done_c2", 32'(r_done), 1);
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      @(negedge w_clk);
      drain(0, 100, 64, 1'b0, 1'b0);

      // Zero-length and reserved-op commands
      a0 = act_cnt;
      send_cmd(OP_LOAD, 3, 0);
      check("len0_done", 32'(r_done), 1);
      @(negedge w_clk);
      check("len0_done_drop", 32'(r_done), 0);
      check("len0_idle", 32'(r_cmd_ready), 1);
      send_cmd(OP_RSVD, 7, 5);
      check("rsvd_done", 32'(r_done), 1);
      @(negedge w_clk);
      check("noop_mem_activity", 32'(act_cnt - a0), 0);

      // Reset after 2 of 4 LOAD beats
      load4(10, 32'h55667788, 2, 1'b0);
      w_rst_n = 1'b0;
      @(negedge w_clk);
      check("midreset_in_ready", 32'(r_in_ready), 0);
      check("midreset_busy", 32'(r_busy), 0);
      check("midreset_row10_cleared", 32'(mem[10]), 0);
      w_rst_n = 1'b1;
      @(negedge w_clk);
      check("midreset_cmd_ready", 32'(r_cmd_ready), 1);
      check("midreset_in_ready_after", 32'(r_in_ready), 0);
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
      drain(10, 4, 4, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
